scr_stack_ctrl: RTL

Stack controller that acts as the initiator for the 256x10 scratch RAM: it owns the stack pointer (SP) and turns push/pop requests from the control unit into scratch-RAM address, write-enable and write-data, capturing popped words from the RAM's asynchronous read port. It sits between the CPU control unit / PUSH, POP, CALL, RET datapath and the scratch RAM, and replaces the ad-hoc SP register and address mux. The stack grows downward: push writes at SP-1, pop reads at SP.

---
 rtl/scr_stack_ctrl.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/scr_stack_ctrl.sv
// -----------------------------------------------------------------------------
// scr_stack_ctrl
//
// Stack controller acting as the initiator for the 256x10 scratch RAM. It owns
// the stack pointer and turns push/pop requests from the control unit into
// scratch-RAM address, write-enable and write-data, and captures popped words
// from the RAM's asynchronous read port. The stack grows downward: a push
// writes at SP-1, a pop reads at SP. All SP arithmetic wraps modulo 2^ADDR_W.
//
// Build option:
//   SCR_STACK_GUARD_EN  when defined, an occupancy counter drives FULL/EMPTY
//                       and overflowing pushes / underflowing pops are
//                       rejected with ACK+ERR. When undefined, FULL=EMPTY=0,
//                       push/pop always execute and ERR only flags a
//                       simultaneous push+pop.
//
// Ports:
//   CLK           rising-edge clock
//   RST_N         synchronous active-low reset
//   PUSH_REQ      push request (sampled in IDLE)
//   POP_REQ       pop request (sampled in IDLE)
//   PUSH_DATA     word to push, captured when the push is accepted
//   SP_LD         load SP from SP_DIN and clear occupancy (sampled in IDLE)
//   SP_DIN        new SP value
//   SCR_DATA_OUT  scratch RAM read data (combinational from SCR_ADDR)
//   SCR_ADDR      scratch RAM address
//   SCR_WE        scratch RAM write enable
//   SCR_DATA_IN   scratch RAM write data
//   POP_DATA      last popped word, held until the next successful pop
//   SP_OUT        current stack pointer
//   BUSY          high whenever the controller is not idle
//   ACK           one-cycle completion pulse per accepted request
//   ERR           qualifies ACK: request rejected, no RAM/SP effect
//   FULL          occupancy == 2^ADDR_W
//   EMPTY         occupancy == 0
// -----------------------------------------------------------------------------
module scr_stack_ctrl #(
    parameter int DATA_W = 10,
    parameter int ADDR_W = 8
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              PUSH_REQ,
    input  logic              POP_REQ,
    input  logic [DATA_W-1:0] PUSH_DATA,
    input  logic              SP_LD,
    input  logic [ADDR_W-1:0] SP_DIN,
    input  logic [DATA_W-1:0] SCR_DATA_OUT,
    output logic [ADDR_W-1:0] SCR_ADDR,
    output logic              SCR_WE,
    output logic [DATA_W-1:0] SCR_DATA_IN,
    output logic [DATA_W-1:0] POP_DATA,
    output logic [ADDR_W-1:0] SP_OUT,
    output logic              BUSY,
    output logic              ACK,
    output logic              ERR,
    output logic              FULL,
    output logic              EMPTY
);

    typedef enum logic [1:0] {IDLE, PUSH, POP, ACKS} state_t;

    state_t            state, state_d;
    logic [ADDR_W-1:0] sp, sp_d;
    logic [DATA_W-1:0] wdata, wdata_d;
    logic [DATA_W-1:0] pop_q, pop_d;
    logic              err_q, err_d;
    logic              full, empty;

`ifdef SCR_STACK_GUARD_EN
    localparam logic [ADDR_W:0] CNT_FULL = {1'b1, {ADDR_W{1'b0}}};

    logic [ADDR_W:0] cnt, cnt_d;

    always_comb begin
        cnt_d = cnt;
        case (state)
            IDLE:    if (SP_LD) cnt_d = '0;
            PUSH:    cnt_d = cnt + 1'b1;
            POP:     cnt_d = cnt - 1'b1;
            default: cnt_d = cnt;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) cnt <= '0;
        else        cnt <= cnt_d;
    end

    assign full  = (cnt == CNT_FULL);
    assign empty = (cnt == '0);
`else
    // Without the guard the stack wraps freely, so it is never full or empty.
    assign full  = 1'b0;
    assign empty = 1'b0;
`endif

    // Next-state, datapath next values and outputs.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path can
        // leave one unassigned and infer a latch.
        state_d     = state;
        sp_d        = sp;
        wdata_d     = wdata;
        pop_d       = pop_q;
        err_d       = err_q;
        SCR_ADDR    = sp;
        SCR_WE      = 1'b0;
        SCR_DATA_IN = wdata;

        case (state)
            IDLE: begin
                err_d = 1'b0;
                if (SP_LD) begin
                    sp_d = SP_DIN;
                end else if (PUSH_REQ && POP_REQ) begin
                    err_d   = 1'b1;
                    state_d = ACKS;
                end else if (PUSH_REQ) begin
                    if (full) begin
                        err_d   = 1'b1;
                        state_d = ACKS;
                    end else begin
                        wdata_d = PUSH_DATA;
                        state_d = PUSH;
                    end
                end else if (POP_REQ) begin
                    if (empty) err_d = 1'b1;
                    state_d = empty ? ACKS : POP;
                end
            end
            PUSH: begin
                SCR_ADDR = sp - 1'b1;
                // Gated with reset so a reset landing mid-push never writes.
                SCR_WE   = RST_N;
                sp_d     = sp - 1'b1;
                state_d  = ACKS;
            end
            POP: begin
                pop_d   = SCR_DATA_OUT;
                sp_d    = sp + 1'b1;
                state_d = ACKS;
            end
            ACKS: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        // NOTE: state registers use non-blocking assignments so every
        // register samples its next value from before the clock edge.
        if (!RST_N) begin
            state <= IDLE;
            sp    <= '0;
            wdata <= '0;
            pop_q <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_d;
            sp    <= sp_d;
            wdata <= wdata_d;
            pop_q <= pop_d;
            err_q <= err_d;
        end
    end

    assign POP_DATA = pop_q;
    assign SP_OUT   = sp;
    assign BUSY     = (state != IDLE);
    assign ACK      = (state == ACKS);
    assign ERR      = (state == ACKS) && err_q;
    assign FULL     = full;
    assign EMPTY    = empty;

endmodule
